vscale_sim_top: RTL and testbench

Simulation top level for the vscale RV32 core. It instantiates the existing `vscale_pipeline` core, an instruction memory `imem` and a data memory `dmem`, and the host-interface (HTIF) PCR agent. The PCR agent holds the `tohost`/`fromhost` CSRs and gives the host bench a valid/ready request/response channel. Test programs are preloaded by backdoor writes into `imem.mem` and `dmem.mem`; pass/fail is reported through `tohost`.

---
 rtl/vscale_sim_top.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_vscale_sim_top.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vscale_sim_top.sv
`default_nettype none
// ============================================================================
// Module   : vscale_sim_top (+ vscale_pipeline, vscale_sim_imem, vscale_sim_dmem)
// Brief    : Simulation top: compact RV32 core, backdoor-loadable memories and
//            the HTIF PCR agent holding tohost/fromhost.
// Revision : 1.0
// ============================================================================

module vscale_pipeline #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] dmem_addr,
    output logic        dmem_wen,
    output logic [1:0]  dmem_size,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    output logic        tohost_wen,
    output logic [31:0] tohost_wdata,
    input  logic [31:0] fromhost
);
    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;
    localparam logic [6:0] OP_SYSTEM = 7'h73;
    localparam logic [11:0] CSR_TO_HOST   = 12'h780;
    localparam logic [11:0] CSR_FROM_HOST = 12'h781;

    logic [31:0] r_pc;
    logic        r_run;
    logic [31:0] r_regs [0:31];

    logic [31:0] w_inst, w_rs1v, w_rs2v, w_pc_plus4, w_next_pc, w_wb_data;
    logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_ld_shift, w_ld_data;
    logic [6:0]  w_op;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_f3;
    logic        w_wb_en, w_take;

    function automatic logic [31:0] alu(input logic [2:0] f, input logic [31:0] a,
                                        input logic [31:0] b, input logic alt);
        case (f)
            3'd0:    alu = alt ? a - b : a + b;
            3'd1:    alu = a << b[4:0];
            3'd2:    alu = {31'b0, $signed(a) < $signed(b)};
            3'd3:    alu = {31'b0, a < b};
            3'd4:    alu = a ^ b;
            3'd5:    alu = alt ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    alu = a | b;
            default: alu = a & b;
        endcase
    endfunction

    assign imem_addr  = r_pc;
    assign w_inst     = imem_rdata;
    assign w_op       = w_inst[6:0];
    assign w_rd       = w_inst[11:7];
    assign w_f3       = w_inst[14:12];
    assign w_rs1      = w_inst[19:15];
    assign w_rs2      = w_inst[24:20];
    assign w_imm_i    = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s    = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b    = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u    = {w_inst[31:12], 12'b0};
    assign w_imm_j    = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_rs1v     = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2v     = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
    assign w_pc_plus4 = r_pc + 32'd4;

    assign dmem_addr    = w_rs1v + ((w_op == OP_STORE) ? w_imm_s : w_imm_i);
    assign dmem_size    = w_f3[1:0];
    assign dmem_wdata   = w_rs2v << {dmem_addr[1:0], 3'b000};
    assign tohost_wdata = w_rs1v;
    assign w_ld_shift   = dmem_rdata >> {dmem_addr[1:0], 3'b000};

    always_comb begin
        w_ld_data = w_ld_shift;
        w_take    = 1'b0;
        case (w_f3)
            3'd0:    w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
            3'd1:    w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
            3'd4:    w_ld_data = {24'b0, w_ld_shift[7:0]};
            3'd5:    w_ld_data = {16'b0, w_ld_shift[15:0]};
            default: w_ld_data = w_ld_shift;
        endcase
        case (w_f3)
            3'd0:    w_take = (w_rs1v == w_rs2v);
            3'd1:    w_take = (w_rs1v != w_rs2v);
            3'd4:    w_take = ($signed(w_rs1v) <  $signed(w_rs2v));
            3'd5:    w_take = ($signed(w_rs1v) >= $signed(w_rs2v));
            3'd6:    w_take = (w_rs1v <  w_rs2v);
            3'd7:    w_take = (w_rs1v >= w_rs2v);
            default: w_take = 1'b0;
        endcase
    end

    // The first cycle after reset release only arms r_run; nothing retires until then.
    always_comb begin
        w_next_pc  = w_pc_plus4;
        w_wb_en    = 1'b0;
        w_wb_data  = 32'd0;
        dmem_wen   = 1'b0;
        tohost_wen = 1'b0;
        case (w_op)
            OP_LUI:    begin w_wb_en = r_run; w_wb_data = w_imm_u; end
            OP_AUIPC:  begin w_wb_en = r_run; w_wb_data = r_pc + w_imm_u; end
            OP_JAL:    begin w_wb_en = r_run; w_wb_data = w_pc_plus4; w_next_pc = r_pc + w_imm_j; end
            OP_JALR:   begin
                w_wb_en   = r_run;
                w_wb_data = w_pc_plus4;
                w_next_pc = (w_rs1v + w_imm_i) & ~32'd1;
            end
            OP_BRANCH: if (w_take) w_next_pc = r_pc + w_imm_b;
            OP_LOAD:   begin w_wb_en = r_run; w_wb_data = w_ld_data; end
            OP_STORE:  dmem_wen = r_run;
            OP_IMM:    begin
                w_wb_en   = r_run;
                w_wb_data = alu(w_f3, w_rs1v, w_imm_i, (w_f3 == 3'd5) && w_inst[30]);
            end
            OP_REG:    begin w_wb_en = r_run; w_wb_data = alu(w_f3, w_rs1v, w_rs2v, w_inst[30]); end
            OP_SYSTEM: if (w_f3 == 3'd1 || w_f3 == 3'd2) begin
                w_wb_en    = r_run;
                w_wb_data  = (w_imm_i[11:0] == CSR_FROM_HOST) ? fromhost : 32'd0;
                tohost_wen = r_run && (w_imm_i[11:0] == CSR_TO_HOST) &&
                             (w_f3 == 3'd1 || w_rs1 != 5'd0);
            end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc  <= RESET_PC;
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_run) r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wb_en && w_rd != 5'd0) r_regs[w_rd] <= w_wb_data;
    end
endmodule

module vscale_sim_imem #(
    parameter int MEM_WORDS = 32768
) (
    input  logic [31:0] addr,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(MEM_WORDS);
    reg [31:0] mem [0:MEM_WORDS-1];
    logic w_unused_addr;

    assign rdata         = mem[addr[AW+1:2]];
    assign w_unused_addr = ^{addr[31:AW+2], addr[1:0]};
endmodule

module vscale_sim_dmem #(
    parameter int MEM_WORDS = 32768
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        wen,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = $clog2(MEM_WORDS);
    reg [31:0] mem [0:MEM_WORDS-1];
    logic [3:0] w_base, w_strb;
    logic       w_unused_addr;

    assign w_base        = (size == 2'd0) ? 4'b0001 : (size == 2'd1) ? 4'b0011 : 4'b1111;
    // Lanes shifted past byte 3 fall off: misaligned stores stay inside the word.
    assign w_strb        = w_base << addr[1:0];
    assign rdata         = mem[addr[AW+1:2]];
    assign w_unused_addr = ^addr[31:AW+2];

    // Plain always: the array is also preloaded hierarchically by the host bench.
    always @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb[i]) mem[addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end
endmodule

module vscale_sim_top #(
    parameter int HTIF_PCR_WIDTH = 64,
    parameter int MEM_WORDS      = 32768
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      htif_pcr_req_valid,
    output logic                      htif_pcr_req_ready,
    input  logic                      htif_pcr_req_rw,
    input  logic [11:0]               htif_pcr_req_addr,
    input  logic [HTIF_PCR_WIDTH-1:0] htif_pcr_req_data,
    output logic                      htif_pcr_resp_valid,
    input  logic                      htif_pcr_resp_ready,
    output logic [HTIF_PCR_WIDTH-1:0] htif_pcr_resp_data
);
    localparam logic [11:0] CSR_ADDR_TO_HOST   = 12'h780;
    localparam logic [11:0] CSR_ADDR_FROM_HOST = 12'h781;

    logic [31:0] w_imem_addr, w_imem_rdata, w_dmem_addr, w_dmem_wdata, w_dmem_rdata;
    logic [31:0] w_tohost_wdata;
    logic [1:0]  w_dmem_size;
    logic        w_dmem_wen, w_tohost_wen, w_req_fire, w_hit_to, w_hit_from;
    logic [HTIF_PCR_WIDTH-1:0] r_tohost, r_fromhost, w_rd_data;

    vscale_pipeline vscale (
        .clk          (clk),
        .reset_n      (reset),
        .imem_addr    (w_imem_addr),
        .imem_rdata   (w_imem_rdata),
        .dmem_addr    (w_dmem_addr),
        .dmem_wen     (w_dmem_wen),
        .dmem_size    (w_dmem_size),
        .dmem_wdata   (w_dmem_wdata),
        .dmem_rdata   (w_dmem_rdata),
        .tohost_wen   (w_tohost_wen),
        .tohost_wdata (w_tohost_wdata),
        .fromhost     (r_fromhost[31:0])
    );

    vscale_sim_imem #(.MEM_WORDS(MEM_WORDS)) imem (
        .addr  (w_imem_addr),
        .rdata (w_imem_rdata)
    );

    vscale_sim_dmem #(.MEM_WORDS(MEM_WORDS)) dmem (
        .clk   (clk),
        .addr  (w_dmem_addr),
        .wen   (w_dmem_wen),
        .size  (w_dmem_size),
        .wdata (w_dmem_wdata),
        .rdata (w_dmem_rdata)
    );

    assign htif_pcr_req_ready = !htif_pcr_resp_valid || htif_pcr_resp_ready;
    assign w_req_fire         = htif_pcr_req_valid && htif_pcr_req_ready;
    assign w_hit_to           = (htif_pcr_req_addr == CSR_ADDR_TO_HOST);
    assign w_hit_from         = (htif_pcr_req_addr == CSR_ADDR_FROM_HOST);
    assign w_rd_data          = w_hit_to ? r_tohost : (w_hit_from ? r_fromhost : '0);

    // Reads and writes both answer with the pre-edge value; a core write to tohost wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tohost            <= '0;
            r_fromhost          <= '0;
            htif_pcr_resp_valid <= 1'b0;
            htif_pcr_resp_data  <= '0;
        end else begin
            if (w_req_fire) begin
                htif_pcr_resp_valid <= 1'b1;
                htif_pcr_resp_data  <= w_rd_data;
            end else if (htif_pcr_resp_ready) begin
                htif_pcr_resp_valid <= 1'b0;
            end
            if (w_tohost_wen)
                r_tohost <= {{(HTIF_PCR_WIDTH-32){1'b0}}, w_tohost_wdata};
            else if (w_req_fire && w_hit_to)
                r_tohost <= htif_pcr_req_rw ? htif_pcr_req_data : '0;
            if (w_req_fire && w_hit_from && htif_pcr_req_rw)
                r_fromhost <= htif_pcr_req_data;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vscale_sim_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_vscale_sim_top
// Brief    : Self-checking bench: host PCR traffic against a register-level
//            model plus small programs exercising the core link and dmem.
// Revision : 1.0
// ============================================================================
module tb_vscale_sim_top;
    localparam logic [11:0] TO   = 12'h780;
    localparam logic [11:0] FROM = 12'h781;
    localparam logic [31:0] JAL_SELF = 32'h0000_006f;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [11:0] req_addr = 12'h0;
    logic [63:0] req_data = 64'h0, resp_data;
    logic        resp_valid, resp_ready = 1'b1;

    int checks = 0;
    int errors = 0;
    logic [63:0] m_tohost = 64'h0, m_fromhost = 64'h0;
    logic [31:0] prog [0:15];
    int          prog_len = 0;

    vscale_sim_top dut (
        .clk                 (clk),
        .reset               (reset),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    // Register-level view of the agent: one access, old value returned.
    function automatic logic [63:0] model_access(input logic rw, input logic [11:0] a, input logic [63:0] d);
        logic [63:0] r;
        r = 64'h0;
        if (a == TO) begin
            r = m_tohost;
            m_tohost = rw ? d : 64'h0;
        end else if (a == FROM) begin
            r = m_fromhost;
            if (rw) m_fromhost = d;
        end
        return r;
    endfunction

    task automatic restart();
        @(negedge clk);
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < prog_len; i++) dut.imem.mem[i] = prog[i];
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_tohost = 64'h0; m_fromhost = 64'h0;
    endtask

    task automatic set_idle_prog();
        prog[0] = JAL_SELF; prog_len = 1;
    endtask

    task automatic host_xfer(input logic rw, input logic [11:0] a, input logic [63:0] d,
                             output logic v, output logic [63:0] r);
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = a; req_data = d; resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        v = resp_valid; r = resp_data;
    endtask

    task automatic test_reset();
        set_idle_prog();
        for (int i = 0; i < prog_len; i++) dut.imem.mem[i] = prog[i];
        req_valid = 1'b1; req_rw = 1'b0; req_addr = TO; resp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
            checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        end
        checks++; if (resp_data !== 64'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
        reset = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL first_resp_valid got %b want 1", resp_valid); end
        checks++; if (resp_data !== 64'h0) begin errors++; $display("FAIL first_resp_data got %h want 0", resp_data); end
    endtask

    task automatic check_tohost_program(input logic [11:0] value, input logic [62:0] exp_code, input string tag);
        logic v; logic [63:0] d, last; int nz, bad_valid;
        prog[0] = enc_i(value, 5'd0, 3'd0, 5'd1, 7'h13);
        prog[1] = enc_i(TO, 5'd1, 3'd1, 5'd0, 7'h73);
        prog[2] = JAL_SELF; prog_len = 3;
        restart();
        nz = 0; bad_valid = 0; last = 64'h0;
        for (int p = 0; p < 20; p++) begin
            host_xfer(1'b0, TO, 64'h0, v, d);
            if (v !== 1'b1) bad_valid++;
            if (d !== 64'h0) begin nz++; last = d; end
        end
        checks++; if (bad_valid != 0) begin errors++; $display("FAIL %s_valid missing %0d want 0", tag, bad_valid); end
        checks++; if (nz != 1) begin errors++; $display("FAIL %s_count got %0d want 1", tag, nz); end
        checks++; if (last !== {52'h0, value}) begin errors++; $display("FAIL %s_data got %h want %h", tag, last, value); end
        checks++; if (last[63:1] !== exp_code) begin errors++; $display("FAIL %s_code got %0d want %0d", tag, last[63:1], exp_code); end
    endtask

    task automatic test_pass();      check_tohost_program(12'd1, 63'd0, "pass"); endtask
    task automatic test_fail_code(); check_tohost_program(12'd7, 63'd3, "failcode"); endtask

    task automatic test_host_write();
        logic v; logic [63:0] d;
        prog[0] = enc_i(FROM, 5'd0, 3'd2, 5'd1, 7'h73);
        prog[1] = enc_b(13'h1FFC, 5'd0, 5'd1, 3'd0);
        prog[2] = enc_s(12'h100, 5'd1, 5'd0, 3'd2);
        prog[3] = enc_i(TO, 5'd1, 3'd1, 5'd0, 7'h73);
        prog[4] = JAL_SELF; prog_len = 5;
        dut.dmem.mem[32'h40] = 32'h0;
        restart();
        host_xfer(1'b1, FROM, 64'h1234, v, d);
        checks++; if (v !== 1'b1 || d !== 64'h0) begin errors++; $display("FAIL hostwr_resp got %b/%h want 1/0", v, d); end
        for (int i = 0; i < 50 && dut.dmem.mem[32'h40] !== 32'h1234; i++) @(negedge clk);
        checks++; if (dut.dmem.mem[32'h40] !== 32'h1234) begin errors++; $display("FAIL core_saw_fromhost got %h want 1234", dut.dmem.mem[32'h40]); end
        d = 64'h0;
        for (int p = 0; p < 20 && d == 64'h0; p++) host_xfer(1'b0, TO, 64'h0, v, d);
        checks++; if (d !== 64'h1234) begin errors++; $display("FAIL core_tohost_echo got %h want 1234", d); end
        for (int k = 0; k < 2; k++) begin
            host_xfer(1'b0, FROM, 64'h0, v, d);
            checks++; if (d !== 64'h1234) begin errors++; $display("FAIL fromhost_read%0d got %h want 1234", k, d); end
        end
    endtask

    task automatic test_backpressure();
        logic v; logic [63:0] d, val, val2;
        set_idle_prog(); restart();
        val = {$urandom(), $urandom()}; val2 = {$urandom(), $urandom()};
        host_xfer(1'b1, FROM, val, v, d);
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = FROM; resp_ready = 1'b0;
        @(negedge clk);
        req_rw = 1'b1; req_data = val2;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (resp_valid !== 1'b1 || resp_data !== val) begin errors++; $display("FAIL stall_resp got %b/%h want 1/%h", resp_valid, resp_data, val); end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_req_ready got %b want 0", req_ready); end
            @(negedge clk);
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        checks++; if (resp_valid !== 1'b1 || resp_data !== val) begin errors++; $display("FAIL queued_write_resp got %b/%h want 1/%h", resp_valid, resp_data, val); end
        host_xfer(1'b0, FROM, 64'h0, v, d);
        checks++; if (d !== val2) begin errors++; $display("FAIL queued_write_effect got %h want %h", d, val2); end
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b0; req_addr = FROM; resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL reset_drops_resp got %b/%b want 0/1", resp_valid, req_ready); end
        @(negedge clk);
        reset = 1'b1; resp_ready = 1'b1;
        host_xfer(1'b0, FROM, 64'h0, v, d);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL reset_clears_fromhost got %h want 0", d); end
    endtask

    task automatic run_random(input int n, input bit hold, input string tag);
        logic m_valid; logic [63:0] m_data; logic exp_ready;
        set_idle_prog(); restart();
        m_valid = 1'b0; m_data = 64'h0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            req_valid  = hold ? 1'b1 : ($urandom_range(0, 3) != 0);
            resp_ready = hold ? 1'b1 : ($urandom_range(0, 2) != 0);
            req_rw     = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       req_addr = TO;
                1:       req_addr = FROM;
                2:       req_addr = TO;
                default: req_addr = 12'($urandom());
            endcase
            req_data = {$urandom(), $urandom()};
            #1;
            exp_ready = !m_valid || resp_ready;
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL %s_req_ready cyc %0d got %b want %b", tag, c, req_ready, exp_ready); end
            checks++; if (resp_valid !== m_valid) begin errors++; $display("FAIL %s_resp_valid cyc %0d got %b want %b", tag, c, resp_valid, m_valid); end
            if (m_valid) begin
                checks++; if (resp_data !== m_data) begin errors++; $display("FAIL %s_resp_data cyc %0d got %h want %h", tag, c, resp_data, m_data); end
            end
            if (req_valid && exp_ready) begin
                m_data  = model_access(req_rw, req_addr, req_data);
                m_valid = 1'b1;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
    endtask

    task automatic test_back_to_back();       run_random(40, 1'b1, "b2b");  endtask
    task automatic test_random_handshake();   run_random(200, 1'b0, "rand"); endtask

    task automatic test_byte_write();
        logic v; logic [63:0] d; logic [31:0] orig0, orig1, exp0;
        orig0 = $urandom(); orig1 = $urandom();
        dut.dmem.mem[32'h400] = orig0;
        dut.dmem.mem[32'h401] = orig1;
        prog[0] = enc_i(12'h0AB, 5'd0, 3'd0, 5'd2, 7'h13);
        prog[1] = {20'h00001, 5'd3, 7'h37};
        prog[2] = enc_s(12'h001, 5'd2, 5'd3, 3'd0);
        prog[3] = enc_i(12'h5CD, 5'd0, 3'd0, 5'd6, 7'h13);
        prog[4] = enc_s(12'h003, 5'd6, 5'd3, 3'd1);
        prog[5] = {20'h00021, 5'd4, 7'h37};
        prog[6] = enc_i(12'h001, 5'd4, 3'd4, 5'd5, 7'h03);
        prog[7] = enc_i(TO, 5'd5, 3'd1, 5'd0, 7'h73);
        prog[8] = JAL_SELF; prog_len = 9;
        restart();
        d = 64'h0;
        for (int p = 0; p < 20 && d == 64'h0; p++) host_xfer(1'b0, TO, 64'h0, v, d);
        checks++; if (d !== 64'hAB) begin errors++; $display("FAIL alias_load got %h want ab", d); end
        exp0 = {8'hCD, orig0[23:16], 8'hAB, orig0[7:0]};
        checks++; if (dut.dmem.mem[32'h400] !== exp0) begin errors++; $display("FAIL byte_lanes got %h want %h", dut.dmem.mem[32'h400], exp0); end
        checks++; if (dut.dmem.mem[32'h401] !== orig1) begin errors++; $display("FAIL misaligned_spill got %h want %h", dut.dmem.mem[32'h401], orig1); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_fail_code();
        test_host_write();
        test_backpressure();
        test_back_to_back();
        test_random_handshake();
        test_byte_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
